// File: rtl/mc_cu_if.sv
// mc_cu_if: bundles the instruction fields, ALU flag, memory handshake and
// every datapath control line between the multi-cycle control unit
// (master) and the datapath/memory side (slave).
interface mc_cu_if;
    logic [5:0] op;
    logic [5:0] func;
    logic       z;
    logic       mem_rdy;
    logic       mem_req;
    logic       iord;
    logic       wir;
    logic       wpc;
    logic       wreg;
    logic       wmem;
    logic       regrt;
    logic       m2reg;
    logic       jal;
    logic       sext;
    logic       shift;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [3:0] aluc;
    logic [1:0] pcsource;
    logic       exc;
    logic       wepc;
    logic [2:0] state;

    modport master (
        input  op, func, z, mem_rdy,
        output mem_req, iord, wir, wpc, wreg, wmem, regrt, m2reg, jal, sext,
               shift, alusrca, alusrcb, aluc, pcsource, exc, wepc, state
    );

    modport slave (
        output op, func, z, mem_rdy,
        input  mem_req, iord, wir, wpc, wreg, wmem, regrt, m2reg, jal, sext,
               shift, alusrca, alusrcb, aluc, pcsource, exc, wepc, state
    );
endinterface

// File: rtl/mc_cu.sv
// mc_cu: multi-cycle control unit for the MIPS-subset CPU.
// Sequences IF -> ID -> EXE -> MEM -> WB and drives the datapath enables as
// a function of the current state and the instruction in IR.
// MEM_HS = 1 makes IF/MEM wait on mem_rdy; 0 treats memory as single cycle.
// Optional feature macro: MC_CU_EXC_EN (illegal instruction trap via state EXC).
module mc_cu #(
    parameter bit MEM_HS = 1'b1
) (
    input  logic    clock,
    input  logic    resetn,
    mc_cu_if.master bus
);

    localparam logic [2:0] S_IF  = 3'd0;
    localparam logic [2:0] S_ID  = 3'd1;
    localparam logic [2:0] S_EXE = 3'd2;
    localparam logic [2:0] S_MEM = 3'd3;
    localparam logic [2:0] S_WB  = 3'd4;
    localparam logic [2:0] S_EXC = 3'd5;

    logic [2:0] state_r;
    logic [2:0] next_s;
    logic       rdy_s;

    logic       is_r_s;
    logic       is_jr_s, is_j_s, is_jal_s;
    logic       is_lw_s, is_sw_s, is_beq_s, is_bne_s;
    logic       is_logic_imm_s, is_shift_s;
    logic       r_legal_s, legal_s;
    logic [3:0] alu_op_s;

    logic       mem_req_s, iord_s, wir_s, wpc_s, wreg_s, wmem_s;
    logic       regrt_s, m2reg_s, jal_s, sext_s, shift_s, alusrca_s;
    logic [1:0] alusrcb_s, pcsource_s;
    logic [3:0] aluc_s;
    logic       exc_s, wepc_s;

    // With the handshake disabled every memory access completes immediately.
    assign rdy_s = MEM_HS ? bus.mem_rdy : 1'b1;

    // Instruction class decode from the IR fields.
    always_comb begin
        is_r_s         = (bus.op == 6'h00);
        is_jr_s        = is_r_s && (bus.func == 6'h08);
        is_j_s         = (bus.op == 6'h02);
        is_jal_s       = (bus.op == 6'h03);
        is_lw_s        = (bus.op == 6'h23);
        is_sw_s        = (bus.op == 6'h2B);
        is_beq_s       = (bus.op == 6'h04);
        is_bne_s       = (bus.op == 6'h05);
        is_logic_imm_s = (bus.op == 6'h0C) || (bus.op == 6'h0D) || (bus.op == 6'h0E);
        is_shift_s     = is_r_s && ((bus.func == 6'h00) || (bus.func == 6'h02) ||
                                    (bus.func == 6'h03));
        case (bus.func)
            6'h20, 6'h22, 6'h24, 6'h25, 6'h26,
            6'h00, 6'h02, 6'h03, 6'h08: r_legal_s = 1'b1;
            default:                    r_legal_s = 1'b0;
        endcase
        case (bus.op)
            6'h00:                         legal_s = r_legal_s;
            6'h08, 6'h0C, 6'h0D, 6'h0E,
            6'h23, 6'h2B, 6'h04, 6'h05,
            6'h0F, 6'h02, 6'h03:           legal_s = 1'b1;
            default:                       legal_s = 1'b0;
        endcase
    end

    // ALU operation selected for the EXE cycle.
    always_comb begin
        alu_op_s = 4'b0000;
        if (is_r_s) begin
            case (bus.func)
                6'h22:   alu_op_s = 4'b0100;
                6'h24:   alu_op_s = 4'b0001;
                6'h25:   alu_op_s = 4'b0101;
                6'h26:   alu_op_s = 4'b0010;
                6'h00:   alu_op_s = 4'b0011;
                6'h02:   alu_op_s = 4'b0111;
                6'h03:   alu_op_s = 4'b1111;
                default: alu_op_s = 4'b0000;
            endcase
        end else begin
            case (bus.op)
                6'h0C:        alu_op_s = 4'b0001;
                6'h0D:        alu_op_s = 4'b0101;
                6'h0E:        alu_op_s = 4'b0010;
                6'h0F:        alu_op_s = 4'b0110;
                6'h04, 6'h05: alu_op_s = 4'b0100;
                default:      alu_op_s = 4'b0000;
            endcase
        end
    end

    // State register; reset parks the sequencer in IF.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_r <= S_IF;
        end else begin
            state_r <= next_s;
        end
    end

    // Next-state and per-state control outputs (Mealy on z and mem_rdy).
    always_comb begin
        next_s     = S_IF;
        mem_req_s  = 1'b0;
        iord_s     = 1'b0;
        wir_s      = 1'b0;
        wpc_s      = 1'b0;
        wreg_s     = 1'b0;
        wmem_s     = 1'b0;
        regrt_s    = 1'b0;
        m2reg_s    = 1'b0;
        jal_s      = 1'b0;
        sext_s     = 1'b0;
        shift_s    = 1'b0;
        alusrca_s  = 1'b0;
        alusrcb_s  = 2'b00;
        aluc_s     = 4'b0000;
        pcsource_s = 2'b00;
        exc_s      = 1'b0;
        wepc_s     = 1'b0;
        case (state_r)
            S_IF: begin
                mem_req_s = 1'b1;
                alusrcb_s = 2'b01;
                if (rdy_s) begin
                    wir_s  = 1'b1;
                    wpc_s  = 1'b1;
                    next_s = S_ID;
                end else begin
                    next_s = S_IF;
                end
            end
            S_ID: begin
                // PC + (imm << 2) is computed here for a possible branch.
                alusrcb_s = 2'b11;
                sext_s    = ~is_logic_imm_s;
                if (!legal_s) begin
`ifdef MC_CU_EXC_EN
                    next_s = S_EXC;
`else
                    next_s = S_IF;
`endif
                end else if (is_j_s) begin
                    wpc_s      = 1'b1;
                    pcsource_s = 2'b11;
                    next_s     = S_IF;
                end else if (is_jr_s) begin
                    wpc_s      = 1'b1;
                    pcsource_s = 2'b10;
                    next_s     = S_IF;
                end else if (is_jal_s) begin
                    wpc_s      = 1'b1;
                    wreg_s     = 1'b1;
                    jal_s      = 1'b1;
                    pcsource_s = 2'b11;
                    next_s     = S_IF;
                end else begin
                    next_s = S_EXE;
                end
            end
            S_EXE: begin
                alusrca_s = 1'b1;
                alusrcb_s = (is_r_s || is_beq_s || is_bne_s) ? 2'b00 : 2'b10;
                aluc_s    = alu_op_s;
                sext_s    = ~is_logic_imm_s;
                shift_s   = is_shift_s;
                if (is_beq_s || is_bne_s) begin
                    wpc_s      = (is_beq_s & bus.z) | (is_bne_s & ~bus.z);
                    pcsource_s = 2'b01;
                    next_s     = S_IF;
                end else if (is_lw_s || is_sw_s) begin
                    next_s = S_MEM;
                end else begin
                    next_s = S_WB;
                end
            end
            S_MEM: begin
                mem_req_s = 1'b1;
                iord_s    = 1'b1;
                wmem_s    = is_sw_s & rdy_s;
                if (rdy_s) begin
                    next_s = is_lw_s ? S_WB : S_IF;
                end else begin
                    next_s = S_MEM;
                end
            end
            S_WB: begin
                wreg_s  = 1'b1;
                m2reg_s = is_lw_s;
                regrt_s = ~is_r_s;
                next_s  = S_IF;
            end
`ifdef MC_CU_EXC_EN
            S_EXC: begin
                exc_s  = 1'b1;
                wepc_s = 1'b1;
                wpc_s  = 1'b1;
                next_s = S_IF;
            end
`else
            S_EXC: begin
                next_s = S_IF;
            end
`endif
            default: begin
                next_s = S_IF;
            end
        endcase
    end

    // Write enables and the memory request are blocked while reset is held.
    assign bus.mem_req  = mem_req_s & resetn;
    assign bus.wir      = wir_s & resetn;
    assign bus.wpc      = wpc_s & resetn;
    assign bus.wreg     = wreg_s & resetn;
    assign bus.wmem     = wmem_s & resetn;
    assign bus.exc      = exc_s & resetn;
    assign bus.wepc     = wepc_s & resetn;
    assign bus.iord     = iord_s;
    assign bus.regrt    = regrt_s;
    assign bus.m2reg    = m2reg_s;
    assign bus.jal      = jal_s;
    assign bus.sext     = sext_s;
    assign bus.shift    = shift_s;
    assign bus.alusrca  = alusrca_s;
    assign bus.alusrcb  = alusrcb_s;
    assign bus.aluc     = aluc_s;
    assign bus.pcsource = pcsource_s;
    assign bus.state    = state_r;

endmodule

// File: tb/tb_mc_cu.sv
// tb_mc_cu: self-checking bench for mc_cu. An instruction table built from
// the ISA description plus a per-state rule model predicts every output in
// every cycle; random instruction streams with random memory waits run back
// to back. Expects the same MC_CU_EXC_EN setting as the design.
module tb_mc_cu;

    logic clk = 1'b0;
    logic rst_n;

    mc_cu_if bus();

    mc_cu u_dut (
        .clock  (clk),
        .resetn (rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    localparam int C_RALU = 0, C_IALU = 1, C_LW = 2, C_SW = 3, C_BEQ = 4;
    localparam int C_BNE = 5, C_J = 6, C_JR = 7, C_JAL = 8, C_ILL = 9;
    localparam int ST_IF = 0, ST_ID = 1, ST_EXE = 2, ST_MEM = 3, ST_WB = 4, ST_EXC = 5;
    localparam logic [24:0] MASK_ALL = 25'h1FFFFFF;
    localparam logic [24:0] MASK_ID  = 25'h1FFEFFF;  // sext is don't-care in ID

    typedef struct {
        logic [5:0] op;
        logic [5:0] func;
        int         cls;
        logic [3:0] aluc;
        logic       sext;
        logic       shift;
    } ins_t;

    ins_t        tbl [0:22];
    ins_t        cur;
    logic [5:0]  cur_func;
    logic        cur_z;
    int          checks = 0;
    int          errors = 0;
    logic [24:0] act_q [$];
    logic [24:0] exp_q [$];
    logic [24:0] msk_q [$];

    function automatic ins_t mk(input logic [5:0] op, input logic [5:0] func, input int cls,
                                input logic [3:0] aluc, input logic sext, input logic shift);
        ins_t t;
        t.op = op; t.func = func; t.cls = cls; t.aluc = aluc; t.sext = sext; t.shift = shift;
        return t;
    endfunction

    task automatic init_tbl();
        tbl[0]  = mk(6'h00, 6'h20, C_RALU, 4'b0000, 1'b1, 1'b0);  // add
        tbl[1]  = mk(6'h00, 6'h22, C_RALU, 4'b0100, 1'b1, 1'b0);  // sub
        tbl[2]  = mk(6'h00, 6'h24, C_RALU, 4'b0001, 1'b1, 1'b0);  // and
        tbl[3]  = mk(6'h00, 6'h25, C_RALU, 4'b0101, 1'b1, 1'b0);  // or
        tbl[4]  = mk(6'h00, 6'h26, C_RALU, 4'b0010, 1'b1, 1'b0);  // xor
        tbl[5]  = mk(6'h00, 6'h00, C_RALU, 4'b0011, 1'b1, 1'b1);  // sll
        tbl[6]  = mk(6'h00, 6'h02, C_RALU, 4'b0111, 1'b1, 1'b1);  // srl
        tbl[7]  = mk(6'h00, 6'h03, C_RALU, 4'b1111, 1'b1, 1'b1);  // sra
        tbl[8]  = mk(6'h00, 6'h08, C_JR,   4'b0000, 1'b1, 1'b0);  // jr
        tbl[9]  = mk(6'h08, 6'h00, C_IALU, 4'b0000, 1'b1, 1'b0);  // addi
        tbl[10] = mk(6'h0C, 6'h00, C_IALU, 4'b0001, 1'b0, 1'b0);  // andi
        tbl[11] = mk(6'h0D, 6'h00, C_IALU, 4'b0101, 1'b0, 1'b0);  // ori
        tbl[12] = mk(6'h0E, 6'h00, C_IALU, 4'b0010, 1'b0, 1'b0);  // xori
        tbl[13] = mk(6'h23, 6'h00, C_LW,   4'b0000, 1'b1, 1'b0);  // lw
        tbl[14] = mk(6'h2B, 6'h00, C_SW,   4'b0000, 1'b1, 1'b0);  // sw
        tbl[15] = mk(6'h04, 6'h00, C_BEQ,  4'b0100, 1'b1, 1'b0);  // beq
        tbl[16] = mk(6'h05, 6'h00, C_BNE,  4'b0100, 1'b1, 1'b0);  // bne
        tbl[17] = mk(6'h0F, 6'h00, C_IALU, 4'b0110, 1'b1, 1'b0);  // lui
        tbl[18] = mk(6'h02, 6'h00, C_J,    4'b0000, 1'b1, 1'b0);  // j
        tbl[19] = mk(6'h03, 6'h00, C_JAL,  4'b0000, 1'b1, 1'b0);  // jal
        tbl[20] = mk(6'h3F, 6'h00, C_ILL,  4'b0000, 1'b1, 1'b0);  // illegal op
        tbl[21] = mk(6'h01, 6'h00, C_ILL,  4'b0000, 1'b1, 1'b0);  // illegal op
        tbl[22] = mk(6'h00, 6'h3F, C_ILL,  4'b0000, 1'b1, 1'b0);  // illegal func
    endtask

    function automatic logic [24:0] pack_act();
        return {bus.state, bus.mem_req, bus.iord, bus.wir, bus.wpc, bus.wreg, bus.wmem,
                bus.regrt, bus.m2reg, bus.jal, bus.sext, bus.shift, bus.alusrca,
                bus.alusrcb, bus.aluc, bus.pcsource, bus.exc, bus.wepc};
    endfunction

    // Expected outputs for one cycle, from the per-state rules of the unit.
    function automatic logic [24:0] exp_vec(input int st, input ins_t ins, input logic rdy,
                                            input logic z);
        logic [2:0] s;
        logic mr, io, wi, wp, wr, wm, rt, m2, jl, se, sh, sa, ex, we;
        logic [1:0] sb, ps;
        logic [3:0] ac;
        s = 3'(st);
        {mr, io, wi, wp, wr, wm, rt, m2, jl, se, sh, sa, ex, we} = 14'd0;
        sb = 2'b00; ps = 2'b00; ac = 4'b0000;
        case (st)
            ST_IF: begin
                mr = 1'b1; sb = 2'b01; wi = rdy; wp = rdy;
            end
            ST_ID: begin
                sb = 2'b11;
                if (ins.cls == C_J)   begin wp = 1'b1; ps = 2'b11; end
                if (ins.cls == C_JR)  begin wp = 1'b1; ps = 2'b10; end
                if (ins.cls == C_JAL) begin wp = 1'b1; wr = 1'b1; jl = 1'b1; ps = 2'b11; end
            end
            ST_EXE: begin
                sa = 1'b1;
                sb = (ins.cls == C_RALU || ins.cls == C_BEQ || ins.cls == C_BNE) ? 2'b00 : 2'b10;
                ac = ins.aluc; se = ins.sext; sh = ins.shift;
                if (ins.cls == C_BEQ) begin wp = z;  ps = 2'b01; end
                if (ins.cls == C_BNE) begin wp = ~z; ps = 2'b01; end
            end
            ST_MEM: begin
                mr = 1'b1; io = 1'b1; wm = (ins.cls == C_SW) && rdy;
            end
            ST_WB: begin
                wr = 1'b1; m2 = (ins.cls == C_LW); rt = (ins.cls != C_RALU);
            end
            ST_EXC: begin
                ex = 1'b1; we = 1'b1; wp = 1'b1;
            end
            default: ;
        endcase
        return {s, mr, io, wi, wp, wr, wm, rt, m2, jl, se, sh, sa, sb, ac, ps, ex, we};
    endfunction

    // Drive one cycle's inputs, then capture actual and predicted outputs.
    task automatic step(input int st, input logic rdy);
        @(negedge clk);
        bus.op      = cur.op;
        bus.func    = cur_func;
        bus.z       = cur_z;
        bus.mem_rdy = rdy;
        #1;
        act_q.push_back(pack_act());
        exp_q.push_back(exp_vec(st, cur, rdy, cur_z));
        msk_q.push_back(st == ST_ID ? MASK_ID : MASK_ALL);
    endtask

    // One instruction with wi IF wait cycles and wm MEM wait cycles.
    task automatic run_instr(input int idx, input logic z_i, input int wi, input int wm);
        cur      = tbl[idx];
        cur_z    = z_i;
        cur_func = (cur.op == 6'h00) ? cur.func : 6'($urandom);
        for (int k = 0; k < wi; k++) step(ST_IF, 1'b0);
        step(ST_IF, 1'b1);
        step(ST_ID, 1'($urandom_range(0, 1)));
        if (cur.cls == C_J || cur.cls == C_JR || cur.cls == C_JAL) return;
        if (cur.cls == C_ILL) begin
`ifdef MC_CU_EXC_EN
            step(ST_EXC, 1'($urandom_range(0, 1)));
`endif
            return;
        end
        step(ST_EXE, 1'($urandom_range(0, 1)));
        if (cur.cls == C_BEQ || cur.cls == C_BNE) return;
        if (cur.cls == C_LW || cur.cls == C_SW) begin
            for (int k = 0; k < wm; k++) step(ST_MEM, 1'b0);
            step(ST_MEM, 1'b1);
            if (cur.cls == C_SW) return;
        end
        step(ST_WB, 1'($urandom_range(0, 1)));
    endtask

    task automatic clear_q();
        act_q.delete(); exp_q.delete(); msk_q.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.op = 6'h02; bus.func = 6'h00; bus.z = 1'b0; bus.mem_rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            checks++;
            if ({bus.state, bus.mem_req, bus.wir, bus.wpc, bus.wreg, bus.wmem} !== 8'd0) begin
                errors++;
                $display("FAIL reset_hold cyc %0d: state=%0d mem_req=%b wir=%b wpc=%b wreg=%b wmem=%b, want all 0",
                         i, bus.state, bus.mem_req, bus.wir, bus.wpc, bus.wreg, bus.wmem);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if ({bus.state, bus.mem_req, bus.iord, bus.wir, bus.wpc, bus.alusrcb} !== 9'b000_1_0_1_1_01) begin
            errors++;
            $display("FAIL reset_first_if: state=%0d mem_req=%b iord=%b wir=%b wpc=%b alusrcb=%b, want 0 1 0 1 1 01",
                     bus.state, bus.mem_req, bus.iord, bus.wir, bus.wpc, bus.alusrcb);
        end
        @(negedge clk); #1;
        checks++;
        if ({bus.state, bus.wpc, bus.pcsource} !== 6'b001_1_11) begin
            errors++;
            $display("FAIL reset_to_id: state=%0d wpc=%b pcsource=%b, want 1 1 11",
                     bus.state, bus.wpc, bus.pcsource);
        end
    endtask

    task automatic test_add();
        clear_q();
        run_instr(0, 1'b0, 0, 0);
        for (int i = 0; i < act_q.size(); i++) begin
            checks++;
            if ((act_q[i] & msk_q[i]) !== (exp_q[i] & msk_q[i])) begin
                errors++;
                $display("FAIL add cyc %0d: got %h want %h", i, act_q[i] & msk_q[i], exp_q[i] & msk_q[i]);
            end
        end
    endtask

    task automatic test_lw_wait();
        clear_q();
        run_instr(13, 1'b0, 0, 2);
        for (int i = 0; i < act_q.size(); i++) begin
            checks++;
            if ((act_q[i] & msk_q[i]) !== (exp_q[i] & msk_q[i])) begin
                errors++;
                $display("FAIL lw_wait cyc %0d: got %h want %h", i, act_q[i] & msk_q[i], exp_q[i] & msk_q[i]);
            end
        end
    endtask

    task automatic test_branch();
        clear_q();
        run_instr(15, 1'b1, 0, 0);
        run_instr(16, 1'b1, 0, 0);
        run_instr(15, 1'b0, 1, 0);
        run_instr(16, 1'b0, 0, 0);
        for (int i = 0; i < act_q.size(); i++) begin
            checks++;
            if ((act_q[i] & msk_q[i]) !== (exp_q[i] & msk_q[i])) begin
                errors++;
                $display("FAIL branch cyc %0d: got %h want %h", i, act_q[i] & msk_q[i], exp_q[i] & msk_q[i]);
            end
        end
    endtask

    task automatic test_jal();
        clear_q();
        run_instr(19, 1'b0, 0, 0);
        run_instr(18, 1'b0, 0, 0);
        run_instr(8, 1'b0, 0, 0);
        for (int i = 0; i < act_q.size(); i++) begin
            checks++;
            if ((act_q[i] & msk_q[i]) !== (exp_q[i] & msk_q[i])) begin
                errors++;
                $display("FAIL jump cyc %0d: got %h want %h", i, act_q[i] & msk_q[i], exp_q[i] & msk_q[i]);
            end
        end
    endtask

    task automatic test_illegal();
        clear_q();
        run_instr(20, 1'b0, 0, 0);
        run_instr(22, 1'b1, 0, 0);
        run_instr(0, 1'b0, 0, 0);
        for (int i = 0; i < act_q.size(); i++) begin
            checks++;
            if ((act_q[i] & msk_q[i]) !== (exp_q[i] & msk_q[i])) begin
                errors++;
                $display("FAIL illegal cyc %0d: got %h want %h", i, act_q[i] & msk_q[i], exp_q[i] & msk_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid_mem();
        clear_q();
        cur = tbl[14]; cur_z = 1'b0; cur_func = 6'h00;
        step(ST_IF, 1'b1);
        step(ST_ID, 1'b0);
        step(ST_EXE, 1'b1);
        step(ST_MEM, 1'b0);
        for (int i = 0; i < act_q.size(); i++) begin
            checks++;
            if ((act_q[i] & msk_q[i]) !== (exp_q[i] & msk_q[i])) begin
                errors++;
                $display("FAIL sw_pre_reset cyc %0d: got %h want %h", i, act_q[i] & msk_q[i], exp_q[i] & msk_q[i]);
            end
        end
        @(negedge clk);
        rst_n = 1'b0;
        bus.mem_rdy = 1'b1;
        #1;
        checks++;
        if ({bus.state, bus.mem_req, bus.wmem} !== 5'd0) begin
            errors++;
            $display("FAIL reset_mid_mem: state=%0d mem_req=%b wmem=%b, want 0 0 0",
                     bus.state, bus.mem_req, bus.wmem);
        end
        @(negedge clk);
        rst_n = 1'b1;
        bus.mem_rdy = 1'b0;
        #1;
        checks++;
        if ({bus.state, bus.mem_req, bus.iord, bus.wir, bus.wmem} !== 7'b000_1_0_0_0) begin
            errors++;
            $display("FAIL refetch_wait: state=%0d mem_req=%b iord=%b wir=%b wmem=%b, want 0 1 0 0 0",
                     bus.state, bus.mem_req, bus.iord, bus.wir, bus.wmem);
        end
    endtask

    task automatic test_back_to_back();
        clear_q();
        for (int n = 0; n < 80; n++) begin
            run_instr(int'($urandom_range(0, 22)), 1'($urandom_range(0, 1)),
                      int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
        end
        for (int i = 0; i < act_q.size(); i++) begin
            checks++;
            if ((act_q[i] & msk_q[i]) !== (exp_q[i] & msk_q[i])) begin
                errors++;
                $display("FAIL random cyc %0d: got %h want %h", i, act_q[i] & msk_q[i], exp_q[i] & msk_q[i]);
            end
        end
    endtask

    initial begin
        init_tbl();
        test_reset();
        test_add();
        test_lw_wait();
        test_branch();
        test_jal();
        test_illegal();
        test_reset_mid_mem();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
